glitcbus_slave: RTL and testbench

GLITCBUS_SLAVE -- requirements
Module: glitcbus_slave

---
 rtl/glitcbus_slave.sv | 161 ++++++++++++++++
 tb/tb_glitcbus_slave.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/glitcbus_slave.sv
// rtl/glitcbus_slave.sv - GLITC bus byte-serial register slave with abort tracking
module glitcbus_slave (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        GSEL_B,
    input  logic        GRDWR_B,
    input  logic [7:0]  gad_i,
    output logic [7:0]  gad_o,
    output logic        gad_oe_o,
    output logic [15:0] reg_adr_o,
    output logic [31:0] reg_dat_o,
    output logic        reg_we_o,
    output logic        reg_rd_o,
    input  logic [31:0] reg_dat_i,
    output logic [7:0]  abort_count_o,
    output logic [15:0] debug_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_ADDRL  = 4'd1,
        S_W3     = 4'd2,
        S_W2     = 4'd3,
        S_W1     = 4'd4,
        S_W0     = 4'd5,
        S_WSTB   = 4'd6,
        S_RREQ   = 4'd7,
        S_RLATCH = 4'd8,
        S_RD3    = 4'd9,
        S_RD2    = 4'd10,
        S_RD1    = 4'd11,
        S_RD0    = 4'd12
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        sel_q;
    logic        rdwr_q;
    logic [31:0] rdata_q;
    logic [15:0] adr_q;
    logic [31:0] dat_q;
    logic [7:0]  abort_q;
    logic        start;
    logic        abort_chk;
    logic        abort;

    // A transaction begins only on a sampled falling edge of select while idle
    assign start = (state == S_IDLE) && !GSEL_B && sel_q;

    // Select is watched in every mid-transaction state except the strobe and the last read byte
    always_comb begin
        abort_chk = 1'b0;
        case (state)
            S_ADDRL, S_W3, S_W2, S_W1, S_W0,
            S_RREQ, S_RLATCH, S_RD3, S_RD2, S_RD1: abort_chk = 1'b1;
            default:                               abort_chk = 1'b0;
        endcase
    end

    assign abort = abort_chk && GSEL_B;

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state sequencing; an abort overrides the normal successor
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_ADDRL;
            S_ADDRL:  next_state = rdwr_q ? S_RREQ : S_W3;
            S_W3:     next_state = S_W2;
            S_W2:     next_state = S_W1;
            S_W1:     next_state = S_W0;
            S_W0:     next_state = S_WSTB;
            S_WSTB:   next_state = S_IDLE;
            S_RREQ:   next_state = S_RLATCH;
            S_RLATCH: next_state = S_RD3;
            S_RD3:    next_state = S_RD2;
            S_RD2:    next_state = S_RD1;
            S_RD1:    next_state = S_RD0;
            S_RD0:    next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
        if (abort) begin
            next_state = S_IDLE;
        end
    end

    // Bus outputs and strobes decoded purely from state so GAD drops the cycle after leaving RD*
    always_comb begin
        gad_oe_o = 1'b0;
        gad_o    = 8'h00;
        reg_we_o = 1'b0;
        reg_rd_o = 1'b0;
        case (state)
            S_WSTB: reg_we_o = 1'b1;
            S_RREQ: reg_rd_o = 1'b1;
            S_RD3: begin
                gad_oe_o = 1'b1;
                gad_o    = rdata_q[31:24];
            end
            S_RD2: begin
                gad_oe_o = 1'b1;
                gad_o    = rdata_q[23:16];
            end
            S_RD1: begin
                gad_oe_o = 1'b1;
                gad_o    = rdata_q[15:8];
            end
            S_RD0: begin
                gad_oe_o = 1'b1;
                gad_o    = rdata_q[7:0];
            end
            default: ;
        endcase
    end

    // Select history, address/data/read capture and the saturating abort counter
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sel_q   <= 1'b1;
            rdwr_q  <= 1'b0;
            rdata_q <= 32'h0;
            adr_q   <= 16'h0;
            dat_q   <= 32'h0;
            abort_q <= 8'h0;
        end else begin
            sel_q <= GSEL_B;
            if (abort && (abort_q != 8'hff)) begin
                abort_q <= abort_q + 8'd1;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        adr_q[15:8] <= gad_i;
                        rdwr_q      <= GRDWR_B;
                    end
                end
                S_ADDRL:  adr_q[7:0]    <= gad_i;
                S_W3:     dat_q[31:24]  <= gad_i;
                S_W2:     dat_q[23:16]  <= gad_i;
                S_W1:     dat_q[15:8]   <= gad_i;
                S_W0:     dat_q[7:0]    <= gad_i;
                S_RLATCH: rdata_q       <= reg_dat_i;
                default: ;
            endcase
        end
    end

    assign reg_adr_o     = adr_q;
    assign reg_dat_o     = dat_q;
    assign abort_count_o = abort_q;
    assign debug_o       = {9'd0, rdwr_q, sel_q, gad_oe_o, state};

endmodule

// File: tb/tb_glitcbus_slave.sv
// tb/tb_glitcbus_slave.sv - directed self-checking bench for glitcbus_slave
module tb_glitcbus_slave;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        GSEL_B = 1'b1;
    logic        GRDWR_B = 1'b0;
    logic [7:0]  gad_i = 8'h00;
    logic [7:0]  gad_o;
    logic        gad_oe_o;
    logic [15:0] reg_adr_o;
    logic [31:0] reg_dat_o;
    logic        reg_we_o;
    logic        reg_rd_o;
    logic [31:0] reg_dat_i = 32'h0;
    logic [7:0]  abort_count_o;
    logic [15:0] debug_o;

    int total = 0;
    int bad = 0;

    glitcbus_slave dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .GSEL_B        (GSEL_B),
        .GRDWR_B       (GRDWR_B),
        .gad_i         (gad_i),
        .gad_o         (gad_o),
        .gad_oe_o      (gad_oe_o),
        .reg_adr_o     (reg_adr_o),
        .reg_dat_o     (reg_dat_o),
        .reg_we_o      (reg_we_o),
        .reg_rd_o      (reg_rd_o),
        .reg_dat_i     (reg_dat_i),
        .abort_count_o (abort_count_o),
        .debug_o       (debug_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive_write(input logic [15:0] a, input logic [31:0] d,
                               output int we_cnt, output int oe_cnt);
        logic [7:0] b [6];
        b[0] = a[15:8];  b[1] = a[7:0];
        b[2] = d[31:24]; b[3] = d[23:16]; b[4] = d[15:8]; b[5] = d[7:0];
        we_cnt = 0;
        oe_cnt = 0;
        GSEL_B = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            GSEL_B  = 1'b0;
            GRDWR_B = (k == 0) ? 1'b0 : 1'b1;
            gad_i   = b[k];
            if (reg_we_o) we_cnt++;
            if (gad_oe_o) oe_cnt++;
            tick();
        end
        GSEL_B = 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (reg_we_o) we_cnt++;
            if (gad_oe_o) oe_cnt++;
            tick();
        end
    endtask

    task automatic test_reset();
        rst_i  = 1'b1;
        GSEL_B = 1'b1;
        tick();
        tick();
        total++; if (gad_oe_o !== 1'b0) begin bad++; $display("FAIL reset_oe: got %b want 0", gad_oe_o); end
        total++; if (gad_o !== 8'h00) begin bad++; $display("FAIL reset_gad: got %h want 00", gad_o); end
        total++; if ({reg_we_o, reg_rd_o} !== 2'b00) begin bad++; $display("FAIL reset_strobes: got %b want 00", {reg_we_o, reg_rd_o}); end
        total++; if (reg_adr_o !== 16'h0) begin bad++; $display("FAIL reset_adr: got %h want 0000", reg_adr_o); end
        total++; if (reg_dat_o !== 32'h0) begin bad++; $display("FAIL reset_dat: got %h want 00000000", reg_dat_o); end
        total++; if (abort_count_o !== 8'h0) begin bad++; $display("FAIL reset_abort: got %0d want 0", abort_count_o); end
        total++; if (debug_o !== 16'h0020) begin bad++; $display("FAIL reset_debug: got %h want 0020", debug_o); end
        rst_i = 1'b0;
        tick();
    endtask

    task automatic test_write();
        logic [7:0] b [6];
        b[0] = 8'h12; b[1] = 8'h34; b[2] = 8'hDE; b[3] = 8'hAD; b[4] = 8'hBE; b[5] = 8'hEF;
        GSEL_B = 1'b1;
        tick();
        for (int k = 0; k < 8; k++) begin
            GSEL_B  = (k <= 5) ? 1'b0 : 1'b1;
            GRDWR_B = (k == 0) ? 1'b0 : 1'b1;
            gad_i   = (k <= 5) ? b[k] : 8'h5A;
            total++; if (reg_we_o !== (k == 6)) begin bad++; $display("FAIL write_we c%0d: got %b want %b", k, reg_we_o, (k == 6)); end
            total++; if (gad_oe_o !== 1'b0) begin bad++; $display("FAIL write_oe c%0d: got %b want 0", k, gad_oe_o); end
            if (k == 6) begin
                total++; if (reg_adr_o !== 16'h1234) begin bad++; $display("FAIL write_adr: got %h want 1234", reg_adr_o); end
                total++; if (reg_dat_o !== 32'hDEADBEEF) begin bad++; $display("FAIL write_dat: got %h want deadbeef", reg_dat_o); end
            end
            tick();
        end
    endtask

    task automatic test_read();
        logic [7:0] exp_b;
        GSEL_B = 1'b1;
        tick();
        for (int k = 0; k < 9; k++) begin
            GSEL_B    = (k <= 6) ? 1'b0 : 1'b1;
            GRDWR_B   = (k == 0) ? 1'b1 : 1'b0;
            gad_i     = (k == 0) ? 8'h00 : (k == 1) ? 8'h10 : 8'h55;
            reg_dat_i = (k == 3) ? 32'hCAFEF00D : 32'h0BAD0BAD;
            case (k)
                4: exp_b = 8'hCA;
                5: exp_b = 8'hFE;
                6: exp_b = 8'hF0;
                7: exp_b = 8'h0D;
                default: exp_b = 8'h00;
            endcase
            total++; if (reg_rd_o !== (k == 2)) begin bad++; $display("FAIL read_rd c%0d: got %b want %b", k, reg_rd_o, (k == 2)); end
            total++; if (gad_oe_o !== (k >= 4 && k <= 7)) begin bad++; $display("FAIL read_oe c%0d: got %b want %b", k, gad_oe_o, (k >= 4 && k <= 7)); end
            total++; if (gad_o !== exp_b) begin bad++; $display("FAIL read_gad c%0d: got %h want %h", k, gad_o, exp_b); end
            total++; if (reg_we_o !== 1'b0) begin bad++; $display("FAIL read_we c%0d: got %b want 0", k, reg_we_o); end
            if (k == 2) begin
                total++; if (reg_adr_o !== 16'h0010) begin bad++; $display("FAIL read_adr: got %h want 0010", reg_adr_o); end
            end
            tick();
        end
    endtask

    task automatic test_abort();
        int we_cnt;
        we_cnt = 0;
        GSEL_B = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            GSEL_B  = (k <= 2) ? 1'b0 : 1'b1;
            GRDWR_B = 1'b0;
            gad_i   = 8'hA0 + 8'(k);
            if (reg_we_o) we_cnt++;
            if (k == 3) begin
                total++; if (abort_count_o !== 8'd0) begin bad++; $display("FAIL abort_pre: got %0d want 0", abort_count_o); end
            end
            tick();
        end
        total++; if (debug_o[3:0] !== 4'd0) begin bad++; $display("FAIL abort_idle: got %0d want 0", debug_o[3:0]); end
        total++; if (abort_count_o !== 8'd1) begin bad++; $display("FAIL abort_one: got %0d want 1", abort_count_o); end
        for (int k = 0; k < 4; k++) begin
            if (reg_we_o) we_cnt++;
            tick();
        end
        for (int i = 0; i < 299; i++) begin
            for (int k = 0; k < 4; k++) begin
                GSEL_B = (k <= 2) ? 1'b0 : 1'b1;
                if (reg_we_o) we_cnt++;
                tick();
            end
        end
        total++; if (abort_count_o !== 8'd255) begin bad++; $display("FAIL abort_sat: got %0d want 255", abort_count_o); end
        total++; if (we_cnt !== 0) begin bad++; $display("FAIL abort_we: got %0d want 0", we_cnt); end
    endtask

    task automatic test_hold_low();
        int we_cnt;
        int oe_cnt;
        we_cnt = 0;
        GSEL_B = 1'b1;
        tick();
        for (int k = 0; k < 20; k++) begin
            GSEL_B  = 1'b0;
            GRDWR_B = 1'b0;
            gad_i   = 8'h40 + 8'(k);
            if (reg_we_o) we_cnt++;
            tick();
        end
        total++; if (we_cnt !== 1) begin bad++; $display("FAIL hold_we: got %0d want 1", we_cnt); end
        total++; if (reg_adr_o !== 16'h4041) begin bad++; $display("FAIL hold_adr: got %h want 4041", reg_adr_o); end
        total++; if (reg_dat_o !== 32'h42434445) begin bad++; $display("FAIL hold_dat: got %h want 42434445", reg_dat_o); end
        drive_write(16'hA55A, 32'h01020304, we_cnt, oe_cnt);
        total++; if (we_cnt !== 1) begin bad++; $display("FAIL hold_next_we: got %0d want 1", we_cnt); end
        total++; if (reg_dat_o !== 32'h01020304) begin bad++; $display("FAIL hold_next_dat: got %h want 01020304", reg_dat_o); end
    endtask

    task automatic test_reset_mid_read();
        int we_cnt;
        int oe_cnt;
        GSEL_B = 1'b1;
        tick();
        for (int k = 0; k < 5; k++) begin
            GSEL_B    = 1'b0;
            GRDWR_B   = (k == 0) ? 1'b1 : 1'b0;
            gad_i     = (k == 0) ? 8'h77 : 8'h88;
            reg_dat_i = 32'h11223344;
            tick();
        end
        total++; if (gad_o !== 8'h22 || gad_oe_o !== 1'b1) begin bad++; $display("FAIL rst_pre: got %b/%h want 1/22", gad_oe_o, gad_o); end
        rst_i = 1'b1;
        tick();
        total++; if (gad_oe_o !== 1'b0 || gad_o !== 8'h00) begin bad++; $display("FAIL rst_mid_gad: got %b/%h want 0/00", gad_oe_o, gad_o); end
        total++; if ({reg_we_o, reg_rd_o} !== 2'b00) begin bad++; $display("FAIL rst_mid_strobe: got %b want 00", {reg_we_o, reg_rd_o}); end
        total++; if (reg_adr_o !== 16'h0 || reg_dat_o !== 32'h0) begin bad++; $display("FAIL rst_mid_regs: got %h/%h want 0/0", reg_adr_o, reg_dat_o); end
        total++; if (abort_count_o !== 8'd0 || debug_o !== 16'h0020) begin bad++; $display("FAIL rst_mid_misc: got %0d/%h want 0/0020", abort_count_o, debug_o); end
        rst_i  = 1'b0;
        GSEL_B = 1'b1;
        drive_write(16'hBEEF, 32'h12345678, we_cnt, oe_cnt);
        total++; if (we_cnt !== 1 || oe_cnt !== 0) begin bad++; $display("FAIL rst_write_cnt: got we=%0d oe=%0d want 1/0", we_cnt, oe_cnt); end
        total++; if (reg_adr_o !== 16'hBEEF || reg_dat_o !== 32'h12345678) begin bad++; $display("FAIL rst_write_regs: got %h/%h want beef/12345678", reg_adr_o, reg_dat_o); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_abort();
        test_hold_low();
        test_reset_mid_read();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
